// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer: phase/state codes and BCD types.
package reaction_pkg;

  // State encoding doubles as the en[1:0] phase code seen downstream.
  typedef enum logic [1:0] {
    EN_DONE   = 2'b00,
    EN_IDLE   = 2'b01,
    EN_WAIT   = 2'b10,
    EN_TIMING = 2'b11
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit saturating BCD counter; clr has priority over inc.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       at_max
);

  logic [3:0][3:0] digit_reg;
  logic [3:0][3:0] digit_next;
  logic [3:0]      is_nine;
  logic [3:0]      carry;
  logic            inc_ok;

  // No increment once the value sits at 9999.
  assign inc_ok = inc && (digit_reg != BCD_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign is_nine[gi] = (digit_reg[gi] == 4'd9);
      // A digit steps when every lower digit is rolling over from 9.
      if (gi == 0) begin : g_c0
        assign carry[gi] = inc_ok;
      end else begin : g_cn
        assign carry[gi] = inc_ok && (&is_nine[gi-1:0]);
      end
      assign digit_next[gi] = carry[gi] ? (is_nine[gi] ? 4'd0 : digit_reg[gi] + 4'd1)
                                        : digit_reg[gi];
    end
  endgenerate

  // High when the value after this edge is 9999, so the FSM can stop on the same edge.
  assign at_max = (digit_next == BCD_MAX);

  assign bcd0 = digit_reg[0];
  assign bcd1 = digit_reg[1];
  assign bcd2 = digit_reg[2];
  assign bcd3 = digit_reg[3];

  // Digit register: reset and clear both force 0000.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= digit_next;
    end
  end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer game control: random pre-GO delay, ms BCD timing, result hand-off.
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int          TICK_DIV     = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       react,
  output logic [1:0] en,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic       led_go
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int             DW         = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]  DELAY_MIN  = DW'(MIN_DELAY_MS);

  state_t         state_reg, state_next;
  logic [PW-1:0]  presc_reg, presc_next;
  logic [DW-1:0]  delay_reg, delay_next;
  logic [15:0]    lfsr_reg, lfsr_next;
  logic           led_go_reg;
  logic [DW-1:0]  delay_load;
  logic           tick;
  logic           bcd_clr;
  logic           bcd_inc;
  logic           bcd_at_max;

  assign tick       = (presc_reg == PRESC_LAST);
  // Fibonacci LFSR, taps 16,14,13,11 (maximal length, never reaches zero).
  assign lfsr_next  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign delay_load = DELAY_MIN + DW'(lfsr_reg[RAND_BITS-1:0]);

  // Start in IDLE/DONE begins a fresh round; react suppresses a coinciding tick.
  assign bcd_clr = start && ((state_reg == EN_IDLE) || (state_reg == EN_DONE));
  assign bcd_inc = (state_reg == EN_TIMING) && tick && !react;

  bcd_counter4 u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bcd_clr),
    .inc     (bcd_inc),
    .bcd0    (BCD0),
    .bcd1    (BCD1),
    .bcd2    (BCD2),
    .bcd3    (BCD3),
    .at_max  (bcd_at_max)
  );

  // Next-state, delay and prescaler logic.
  always_comb begin
    state_next = state_reg;
    delay_next = delay_reg;
    case (state_reg)
      EN_IDLE, EN_DONE: begin
        if (start) begin
          state_next = EN_WAIT;
          delay_next = delay_load;
        end
      end
      EN_WAIT: begin
        if (react) begin
          state_next = EN_DONE;            // false start, BCD stays 0000
        end else if (tick) begin
          if (delay_reg == DW'(1)) begin
            state_next = EN_TIMING;
          end
          delay_next = delay_reg - 1'b1;
        end
      end
      EN_TIMING: begin
        if (react) begin
          state_next = EN_DONE;
        end else if (tick && bcd_at_max) begin
          state_next = EN_DONE;            // timeout at 9999
        end
      end
      default: state_next = EN_IDLE;
    endcase
    // Clearing on every state change absorbs a tick landing on the transition edge.
    presc_next = ((state_next != state_reg) || tick) ? '0 : presc_reg + 1'b1;
  end

  // State, prescaler, delay, LFSR and GO LED registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= EN_IDLE;
      presc_reg  <= '0;
      delay_reg  <= '0;
      lfsr_reg   <= LFSR_SEED;
      led_go_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      delay_reg  <= delay_next;
      lfsr_reg   <= lfsr_next;
      led_go_reg <= (state_next == EN_TIMING);
    end
  end

  assign en     = state_reg;
  assign led_go = led_go_reg;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed self-checking bench for reaction_timer_core (TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2).
module tb_reaction_timer_core;

  localparam int          TICK = 4;
  localparam int          MIND = 3;
  localparam int          RB   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        react;
  logic [1:0]  en;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3;
  logic        led_go;
  logic [15:0] bcd_val;
  logic [15:0] lfsr_m;

  int n_checks;
  int n_pass;
  int d;
  bit saw_done;
  bit saw_led;

  reaction_timer_core #(
    .TICK_DIV     (TICK),
    .MIN_DELAY_MS (MIND),
    .RAND_BITS    (RB),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .react   (react),
    .en      (en),
    .BCD0    (BCD0),
    .BCD1    (BCD1),
    .BCD2    (BCD2),
    .BCD3    (BCD3),
    .led_go  (led_go)
  );

  assign bcd_val = {BCD3, BCD2, BCD1, BCD0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR used to predict the pre-GO delay of each round.
  always @(posedge clk) begin
    if (!reset_n) lfsr_m <= SEED;
    else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n falling edges, noting any DONE code or GO LED seen on the way.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (en == 2'b00) saw_done = 1'b1;
      if (led_go)      saw_led  = 1'b1;
    end
  endtask

  task automatic react_pulse();
    react = 1'b1;
    step(1);
    react = 1'b0;
  endtask

  // Press start and follow the round to GO; leaves the bench half a cycle after GO.
  task automatic go_round(output int dl);
    dl = MIND + int'(lfsr_m[RB-1:0]);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("wait_en", en, 2'b10);
    check("wait_bcd", bcd_val, 16'h0000);
    step(4 * dl - 1);
    check("go_early", led_go, 1'b0);
    step(1);
    check("go_rise", led_go, 1'b1);
    check("timing_en", en, 2'b11);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    saw_done = 1'b0;
    saw_led  = 1'b0;
    start    = 1'b0;
    react    = 1'b0;
    reset_n  = 1'b0;

    step(3);
    check("reset_en", en, 2'b01);
    check("reset_bcd", bcd_val, 16'h0000);
    check("reset_led", led_go, 1'b0);
    reset_n = 1'b1;

    react_pulse();
    check("idle_react_en", en, 2'b01);
    $display("round idle: en=%b bcd=%h led_go=%b", en, bcd_val, led_go);

    // Normal round, react after 37 ticks
    go_round(d);
    step(148);
    react_pulse();
    check("normal_en", en, 2'b00);
    check("normal_bcd", bcd_val, 16'h0037);
    check("normal_led", led_go, 1'b0);
    step(20);
    check("hold_en", en, 2'b00);
    check("hold_bcd", bcd_val, 16'h0037);
    $display("round normal: delay=%0d en=%b bcd=%h led_go=%b", d, en, bcd_val, led_go);

    // Start and react together in DONE: start wins
    start = 1'b1;
    react = 1'b1;
    step(1);
    start = 1'b0;
    react = 1'b0;
    check("prio_en", en, 2'b10);
    check("prio_bcd", bcd_val, 16'h0000);

    // False start two ticks into WAIT
    saw_led = 1'b0;
    step(8);
    react_pulse();
    check("false_en", en, 2'b00);
    check("false_bcd", bcd_val, 16'h0000);
    check("false_led_seen", saw_led, 1'b0);
    $display("round false_start: en=%b bcd=%h led_go=%b", en, bcd_val, led_go);

    // Decimal carry through 0099 -> 0100
    go_round(d);
    step(396);
    check("carry_99", bcd_val, 16'h0099);
    check("carry_99_en", en, 2'b11);
    step(4);
    react_pulse();
    check("carry_100", bcd_val, 16'h0100);
    check("carry_en", en, 2'b00);
    $display("round carry: delay=%0d en=%b bcd=%h led_go=%b", d, en, bcd_val, led_go);

    // React on the same edge as the fifth tick: that tick is dropped
    go_round(d);
    step(4 * 5 - 1);
    react_pulse();
    check("coinc_bcd", bcd_val, 16'h0004);
    check("coinc_en", en, 2'b00);
    $display("round coincide: delay=%0d en=%b bcd=%h led_go=%b", d, en, bcd_val, led_go);

    // Reset in the middle of TIMING
    saw_done = 1'b0;
    go_round(d);
    step(10);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("midrst_en", en, 2'b01);
    check("midrst_bcd", bcd_val, 16'h0000);
    check("midrst_led", led_go, 1'b0);
    step(6);
    check("midrst_stay", en, 2'b01);
    check("midrst_no_done", saw_done, 1'b0);
    $display("round mid_reset: en=%b bcd=%h led_go=%b", en, bcd_val, led_go);

    // Saturation at 9999 with no react
    go_round(d);
    step(4 * 9999 - 1);
    check("sat_pre_bcd", bcd_val, 16'h9998);
    check("sat_pre_en", en, 2'b11);
    step(1);
    check("sat_en", en, 2'b00);
    check("sat_bcd", bcd_val, 16'h9999);
    check("sat_led", led_go, 1'b0);
    step(3);
    react_pulse();
    step(3);
    check("sat_hold_en", en, 2'b00);
    check("sat_hold_bcd", bcd_val, 16'h9999);
    check("sat_hold_led", led_go, 1'b0);
    $display("round saturate: delay=%0d en=%b bcd=%h led_go=%b", d, en, bcd_val, led_go);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
